// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage pipeline plus the mult/div busy sequencer.
// Outputs are combinational, with zero added latency. The stall output holds F/D and bubbles E; while reset is high it forces the flushes on.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       PCSrcD,
    input  logic       JumpD,
    input  logic       MdStartE,
    input  logic       MdDivE,
    input  logic       MdUseD,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       MdBusy,
    output logic       MdDone
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 2);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 2);

    logic [1:0] state;
    logic [5:0] cnt;
    logic       flush_q;
    logic       lwstall;
    logic       brstall;
    logic       mdstall;
    logic       stall;
    logic [5:0] md_load;

    // Register $0 is hardwired zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    always_comb begin
        lwstall = MemtoRegE & (reg_hit(RtE, RsD) | reg_hit(RtE, RtD));
        brstall = BranchD &
                  ((RegWriteE & (reg_hit(WriteRegE, RsD) | reg_hit(WriteRegE, RtD))) |
                   (MemtoRegM & (reg_hit(WriteRegM, RsD) | reg_hit(WriteRegM, RtD))));
        mdstall = MdUseD & ((state == S_BUSY) | ((state == S_IDLE) & MdStartE));
        stall   = lwstall | brstall | mdstall;
        md_load = MdDivE ? DIV_LOAD : MULT_LOAD;
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        MdBusy    = 1'b0;
        MdDone    = 1'b0;
        if (!reset) begin
            StallF = stall;
            StallD = stall;
            FlushE = stall;
            // A redirect is dropped while D is held; it is seen again once released.
            FlushD = (PCSrcD | JumpD) & ~stall;
            if (RegWriteM && reg_hit(WriteRegM, RsE))      ForwardAE = 2'b10;
            else if (RegWriteW && reg_hit(WriteRegW, RsE)) ForwardAE = 2'b01;
            if (RegWriteM && reg_hit(WriteRegM, RtE))      ForwardBE = 2'b10;
            else if (RegWriteW && reg_hit(WriteRegW, RtE)) ForwardBE = 2'b01;
            ForwardAD = RegWriteM & reg_hit(WriteRegM, RsD);
            ForwardBD = RegWriteM & reg_hit(WriteRegM, RtD);
            MdBusy    = (state == S_BUSY);
            MdDone    = (state == S_DONE);
        end
    end

    // flush_q marks that the instruction now in E was bubbled on entry, so its start is void.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 6'd0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= stall;
            case (state)
                S_IDLE: begin
                    if (MdStartE && !flush_q) begin
                        cnt   <= md_load;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt == 6'd0) state <= S_DONE;
                    else             cnt   <= cnt - 6'd1;
                end
                S_DONE: begin
                    if (MdStartE) begin
                        cnt   <= md_load;
                        state <= S_BUSY;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector table for the combinational hazard logic plus hand sequences for the mult/div sequencer.
module tb_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, JumpD, MdStartE, MdDivE, MdUseD;
    logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MdBusy, MdDone;
    logic [1:0] ForwardAE, ForwardBE;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clock(clock), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
        .MdStartE(MdStartE), .MdDivE(MdDivE), .MdUseD(MdUseD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .MdBusy(MdBusy), .MdDone(MdDone)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
        logic       rwe, rwm, rww, mte, mtm, br, pcs, jmp, mdu;
        logic       x_stall, x_flushd;
        logic [1:0] x_fae, x_fbe;
        logic       x_fad, x_fbd;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0;
        BranchD = 0; PCSrcD = 0; JumpD = 0;
        MdStartE = 0; MdDivE = 0; MdUseD = 0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_stall(input string nm, input int exp);
        chk({nm, ".StallF"}, int'(StallF), exp);
        chk({nm, ".StallD"}, int'(StallD), exp);
        chk({nm, ".FlushE"}, int'(FlushE), exp);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, ".StallF"}, int'(StallF), 0);
        chk({nm, ".StallD"}, int'(StallD), 0);
        chk({nm, ".FlushD"}, int'(FlushD), 1);
        chk({nm, ".FlushE"}, int'(FlushE), 1);
        chk({nm, ".ForwardAE"}, int'(ForwardAE), 0);
        chk({nm, ".ForwardBE"}, int'(ForwardBE), 0);
        chk({nm, ".ForwardAD"}, int'(ForwardAD), 0);
        chk({nm, ".ForwardBD"}, int'(ForwardBD), 0);
        chk({nm, ".MdBusy"}, int'(MdBusy), 0);
        chk({nm, ".MdDone"}, int'(MdDone), 0);
    endtask

    initial begin
        //            rsd rtd rse rte wre wrm wrw rwe rwm rww mte mtm br pcs jmp mdu | stall flD fAE fBE fAD fBD
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0, 0};
        vecs[1]  = '{2, 0, 0, 2, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 0, 0};
        vecs[2]  = '{1, 7, 0, 7, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 0, 0};
        vecs[3]  = '{0, 0, 4, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0, 0};
        vecs[4]  = '{0, 0, 5, 0, 0, 5, 5,  0, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 2'b10, 2'b00, 0, 0};
        vecs[5]  = '{0, 0, 2, 2, 0, 0, 2,  0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 2'b01, 2'b01, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0, 0};
        vecs[7]  = '{0, 0, 3, 9, 0, 9, 3,  0, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 2'b01, 2'b10, 0, 0};
        vecs[8]  = '{4, 4, 0, 0, 0, 4, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 1, 1};
        vecs[9]  = '{3, 0, 0, 0, 3, 0, 0,  1, 0, 0, 0, 0, 1, 1, 0, 0,  1, 0, 2'b00, 2'b00, 0, 0};
        vecs[10] = '{1, 6, 0, 0, 0, 6, 0,  0, 1, 0, 0, 1, 1, 0, 0, 0,  1, 0, 2'b00, 2'b00, 0, 1};
        vecs[11] = '{3, 0, 0, 0, 0, 3, 0,  0, 1, 0, 0, 0, 1, 1, 0, 0,  0, 1, 2'b00, 2'b00, 1, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 2'b00, 2'b00, 0, 0};
        vecs[13] = '{2, 0, 0, 2, 0, 0, 0,  0, 0, 0, 1, 0, 1, 1, 0, 0,  1, 0, 2'b00, 2'b00, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 1, 0, 0,  0, 1, 2'b00, 2'b00, 0, 0};
        vecs[15] = '{3, 0, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0, 0};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 2'b00, 2'b00, 0, 0};
        vecs[17] = '{0, 6, 0, 0, 0, 6, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0, 0};

        // Reset with inputs that would otherwise stall and forward.
        clear_inputs();
        reset = 1'b1;
        RsD = 2; RtE = 2; MemtoRegE = 1; RsE = 5; WriteRegM = 5; RegWriteM = 1; PCSrcD = 0;
        MdUseD = 1; MdStartE = 1;
        @(negedge clock);
        chk_reset_outs("reset");
        next_cycle();
        clear_inputs();
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < NVEC; i++) begin
            RsD = vecs[i].rsd; RtD = vecs[i].rtd; RsE = vecs[i].rse; RtE = vecs[i].rte;
            WriteRegE = vecs[i].wre; WriteRegM = vecs[i].wrm; WriteRegW = vecs[i].wrw;
            RegWriteE = vecs[i].rwe; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            MemtoRegE = vecs[i].mte; MemtoRegM = vecs[i].mtm;
            BranchD = vecs[i].br; PCSrcD = vecs[i].pcs; JumpD = vecs[i].jmp;
            MdStartE = 1'b0; MdDivE = 1'b0; MdUseD = vecs[i].mdu;
            @(negedge clock);
            chk_stall($sformatf("vec%0d", i), int'(vecs[i].x_stall));
            chk($sformatf("vec%0d.FlushD", i), int'(FlushD), int'(vecs[i].x_flushd));
            chk($sformatf("vec%0d.ForwardAE", i), int'(ForwardAE), int'(vecs[i].x_fae));
            chk($sformatf("vec%0d.ForwardBE", i), int'(ForwardBE), int'(vecs[i].x_fbe));
            chk($sformatf("vec%0d.ForwardAD", i), int'(ForwardAD), int'(vecs[i].x_fad));
            chk($sformatf("vec%0d.ForwardBD", i), int'(ForwardBD), int'(vecs[i].x_fbd));
            next_cycle();
        end

        // Load-use: one stall cycle, then the loaded value forwards from W.
        clear_inputs();
        next_cycle();
        MemtoRegE = 1; RtE = 2; RsD = 2;
        @(negedge clock);
        chk_stall("lu.c0", 1);
        next_cycle();
        clear_inputs();
        RsE = 2; RegWriteW = 1; WriteRegW = 2;
        @(negedge clock);
        chk_stall("lu.c1", 0);
        chk("lu.c1.ForwardAE", int'(ForwardAE), 1);
        next_cycle();

        // Branch on a value produced in E, then compared with M forwarding and taken.
        clear_inputs();
        BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3; PCSrcD = 1;
        @(negedge clock);
        chk_stall("br.c0", 1);
        chk("br.c0.FlushD", int'(FlushD), 0);
        next_cycle();
        clear_inputs();
        BranchD = 1; RsD = 3; RegWriteM = 1; WriteRegM = 3; PCSrcD = 1;
        @(negedge clock);
        chk_stall("br.c1", 0);
        chk("br.c1.ForwardAD", int'(ForwardAD), 1);
        chk("br.c1.FlushD", int'(FlushD), 1);
        next_cycle();

        // Multiply with a dependent instruction held in D.
        clear_inputs();
        next_cycle();
        for (int k = 0; k <= 5; k++) begin
            MdStartE = (k == 0);
            MdDivE   = 1'b0;
            MdUseD   = (k <= 4);
            @(negedge clock);
            chk_stall($sformatf("mul.k%0d", k), int'(k <= 3));
            chk($sformatf("mul.k%0d.MdBusy", k), int'(MdBusy), int'(k >= 1 && k <= 3));
            chk($sformatf("mul.k%0d.MdDone", k), int'(MdDone), int'(k == 4));
            next_cycle();
        end

        // Back-to-back divides: second start lands in the DONE cycle.
        clear_inputs();
        next_cycle();
        for (int k = 0; k <= 70; k++) begin
            MdStartE = (k == 0 || k == 32);
            MdDivE   = 1'b1;
            @(negedge clock);
            chk($sformatf("div.k%0d.MdBusy", k), int'(MdBusy),
                int'((k >= 1 && k <= 31) || (k >= 33 && k <= 63)));
            chk($sformatf("div.k%0d.MdDone", k), int'(MdDone), int'(k == 32 || k == 64));
            next_cycle();
        end

        // Reset in the tenth BUSY cycle of a divide aborts it with no completion.
        clear_inputs();
        next_cycle();
        for (int k = 0; k <= 10; k++) begin
            MdStartE = (k == 0);
            MdDivE   = 1'b1;
            if (k == 10) begin
                reset = 1'b1;
                MdUseD = 1; MemtoRegE = 1; RtE = 4; RsD = 4; JumpD = 0;
                @(negedge clock);
                chk_reset_outs("rstdiv");
            end else begin
                @(negedge clock);
                chk($sformatf("rstdiv.k%0d.MdBusy", k), int'(MdBusy), int'(k >= 1));
            end
            next_cycle();
        end
        clear_inputs();
        reset  = 1'b0;
        MdUseD = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            chk($sformatf("post.k%0d.MdDone", k), int'(MdDone), 0);
            chk($sformatf("post.k%0d.MdBusy", k), int'(MdBusy), 0);
            chk($sformatf("post.k%0d.StallF", k), int'(StallF), 0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. Generates stall, flush and forwarding controls for the IF/ID, ID/EX and later pipeline registers. Detects load-use and branch-compare hazards and owns a multi-cycle multiply/divide busy sequencer that holds dependent instructions in decode. Sits beside the datapath and drives the enable/clear inputs of the stage registers.

## Interface
- MULT_CYCLES, 4, EX-to-result latency of multiply (≥2)
- DIV_CYCLES, 32, EX-to-result latency of divide (≥2, ≤63)

- clock  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- RsD, RtD  in  5 each  source registers of instruction in D
- RsE, RtE  in  5 each  source registers of instruction in E
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1 each  destination write enable per stage
- MemtoRegE, MemtoRegM  in  1 each  instruction is a load
- BranchD  in  1  branch in D, compared in D
- PCSrcD  in  1  branch taken, resolved in D
- JumpD  in  1  jump in D
- MdStartE  in  1  mult/div instruction in E
- MdDivE  in  1  with MdStartE: 1 = divide, 0 = multiply
- MdUseD  in  1  instruction in D reads HI/LO or starts mult/div
- StallF, StallD  out  1  hold PC / IF-ID register
- FlushD, FlushE  out  1  clear IF-ID / ID-EX register to bubble
- ForwardAE, ForwardBE  out  2  EX operand select: 00 regfile, 10 from M, 01 from W
- ForwardAD, ForwardBD  out  1  branch comparator operand from M
- MdBusy  out  1  sequencer in BUSY
- MdDone  out  1  one-cycle pulse, HI/LO valid next cycle

## Operation
- Register $0 never matches in any hazard or forward compare.
- Forwarding (combinational): ForwardAE = 10 if RegWriteM & WriteRegM==RsE; else 01 if RegWriteW & WriteRegW==RsE; else 00. M wins over W. Same for ForwardBE with RtE. ForwardAD = RegWriteM & WriteRegM==RsD; ForwardBD likewise with RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- brstall = BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})).
- mdstall = MdUseD & (state==BUSY | (state==IDLE & MdStartE)).
- stall = lwstall | brstall | mdstall; StallF = StallD = FlushE = stall.
- FlushD = (PCSrcD | JumpD) & ~stall (redirect is ignored while D is stalled; re-evaluated when released).
- Sequencer FSM, states IDLE, BUSY, DONE:
  - IDLE: MdStartE & ~FlushE-of-that-instruction -> load cnt = (MdDivE ? DIV_CYCLES : MULT_CYCLES) − 2, go BUSY.
  - BUSY: cnt==0 -> DONE; else cnt−1. MdStartE ignored (cannot occur; mdstall blocks it).
  - DONE: MdDone=1 for this cycle; MdStartE -> reload cnt, go BUSY; else IDLE.
- cnt is 6 bits, never wraps (loads only in IDLE/DONE).

## Timing
- All stall/flush/forward outputs combinational from inputs and FSM state, no added latency.
- Multiply: MdStartE at cycle t -> MdBusy t+1..t+MULT_CYCLES−1, MdDone at t+MULT_CYCLES.
- Reset (while reset=1, regardless of other inputs): state IDLE, cnt 0, MdBusy 0, MdDone 0, StallF 0, StallD 0, FlushD 1, FlushE 1, Forward* 0. First non-reset cycle behaves as IDLE.
- Reset asserted mid-BUSY aborts the operation; no MdDone pulse.
- Simultaneous lwstall and taken branch in D: stall wins, FlushD=0.
- Simultaneous mdstall and lwstall: single combined stall, no double bubble.

## Test plan
- Load-use: lw $2 in E (MemtoRegE=1, RtE=2), add with RsD=2 -> one cycle StallF=StallD=FlushE=1, then ForwardAE=01 next cycle with RsE=2, WriteRegW=2.
- Double forward: RegWriteM=RegWriteW=1, WriteRegM=WriteRegW=5, RsE=5 -> ForwardAE=10; RsE=0 with WriteRegM=0 -> 00.
- Branch: BranchD, RsD=3, RegWriteE=1, WriteRegE=3 -> stall 1 cycle; next cycle WriteRegM=3 -> ForwardAD=1, PCSrcD=1 -> FlushD=1.
- Multiply: MdStartE, MdDivE=0 at t, MdUseD=1 from t -> stall cycles t..t+3, MdDone at t+4, stall low at t+4.
- Divide back-to-back: MdStartE in DONE cycle -> BUSY again, second MdDone exactly DIV_CYCLES later.
- Reset mid-divide at BUSY cycle 10 -> all outputs reset values, MdBusy 0, no MdDone for 40 cycles.
